// File: rtl/vita_tx_report_pkt_if.sv
// Report packet stream: 36-bit FIFO word with src/dst handshake.
// Ports: err_data_o, err_src_rdy_o (master out), err_dst_rdy_i (master in).
interface vita_tx_report_pkt_if;
  logic [35:0] err_data_o;
  logic        err_src_rdy_o;
  logic        err_dst_rdy_i;

  modport master (
    output err_data_o,
    output err_src_rdy_o,
    input  err_dst_rdy_i
  );

  modport slave (
    input  err_data_o,
    input  err_src_rdy_o,
    output err_dst_rdy_i
  );
endinterface

// File: rtl/vita_tx_report_pkt.sv
// Packs tx error/ack events into 6-word VITA context packets.
// Ports: clk, reset_n, clear, settings bus, vita_time, error/ack/error_code,
// rpt (36b FIFO master), dropped (saturating drop count).
module vita_tx_report_pkt #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic        error,
  input  logic        ack,
  input  logic [31:0] error_code,
  vita_tx_report_pkt_if.master rpt,
  output logic [15:0] dropped
);

  typedef enum logic [2:0] {
    IDLE, HDR, SID, TSH, TSL, CODE, TAIL
  } state_t;

  state_t      state;
  logic [31:0] stream_id;
  logic [31:0] act_code;
  logic [63:0] act_time;
  logic [31:0] pend_code;
  logic [63:0] pend_time;
  logic        pend_valid;
  logic [3:0]  pkt_cnt;

  logic        ev;
  logic        xfer;
  logic        tail_xfer;
  logic        drop;
  logic [15:0] dropped_nxt;
  logic [3:0]  cnt_inc;

  function automatic logic [35:0] hdr_word(input logic [3:0] c);
    hdr_word = {4'b0001, 4'h4, 4'h0, 4'h1, c, 16'd6};
  endfunction

  always_comb begin
    ev        = error | ack;
    xfer      = rpt.err_src_rdy_o & rpt.err_dst_rdy_i;
    tail_xfer = xfer & (state == TAIL);
    cnt_inc   = pkt_cnt + 4'd1;
    drop      = ev & (state != IDLE) & pend_valid & ~tail_xfer;
    dropped_nxt = dropped;
    if (drop && dropped != 16'hFFFF)
      dropped_nxt = dropped + 16'd1;
  end

  // Stream ID survives clear; only reset_n returns it to zero.
  always_ff @(posedge clk) begin
    if (!reset_n)
      stream_id <= '0;
    else if (set_stb && set_addr == BASE)
      stream_id <= set_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state             <= IDLE;
      rpt.err_src_rdy_o <= 1'b0;
      rpt.err_data_o    <= '0;
      pend_valid        <= 1'b0;
      pend_code         <= '0;
      pend_time         <= '0;
      act_code          <= '0;
      act_time          <= '0;
      dropped           <= '0;
      pkt_cnt           <= '0;
    end else begin
      dropped <= dropped_nxt;
      case (state)
        IDLE: begin
          if (ev) begin
            act_code          <= error_code;
            act_time          <= vita_time;
            state             <= HDR;
            rpt.err_src_rdy_o <= 1'b1;
            rpt.err_data_o    <= hdr_word(pkt_cnt);
          end
        end
        default: begin
          if (ev && !pend_valid && !tail_xfer) begin
            pend_code  <= error_code;
            pend_time  <= vita_time;
            pend_valid <= 1'b1;
          end
          if (xfer) begin
            case (state)
              HDR: begin
                state          <= SID;
                rpt.err_data_o <= {4'h0, stream_id};
              end
              SID: begin
                state          <= TSH;
                rpt.err_data_o <= {4'h0, act_time[63:32]};
              end
              TSH: begin
                state          <= TSL;
                rpt.err_data_o <= {4'h0, act_time[31:0]};
              end
              TSL: begin
                state          <= CODE;
                rpt.err_data_o <= {4'h0, act_code};
              end
              CODE: begin
                state          <= TAIL;
                rpt.err_data_o <= {4'b0010, 16'd0, dropped_nxt};
              end
              TAIL: begin
                pkt_cnt <= cnt_inc;
                // Pending event goes first; a same-cycle event refills the slot.
                if (pend_valid) begin
                  act_code       <= pend_code;
                  act_time       <= pend_time;
                  state          <= HDR;
                  rpt.err_data_o <= hdr_word(cnt_inc);
                  if (ev) begin
                    pend_code <= error_code;
                    pend_time <= vita_time;
                  end else begin
                    pend_valid <= 1'b0;
                  end
                end else if (ev) begin
                  act_code       <= error_code;
                  act_time       <= vita_time;
                  state          <= HDR;
                  rpt.err_data_o <= hdr_word(cnt_inc);
                end else begin
                  state             <= IDLE;
                  rpt.err_src_rdy_o <= 1'b0;
                  rpt.err_data_o    <= '0;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
